// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: bus widths, reset PC, NOP
// encoding and the fetch-buffer entry layout.
package if_fetch_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;
  localparam int unsigned ENTRY_W = XLEN + ILEN;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;
  localparam logic [ILEN-1:0] NOP_INST = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP = 64'h0000_0000_0000_0004;

  // One buffered fetch result: PC in the upper bits, instruction in the lower.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/if_fetch_fifo.sv
// Small in-order buffer for fetched {pc, inst} pairs. Flush empties it in one
// cycle; a push into a full buffer is accepted only together with a pop.
module if_fetch_fifo #(
  parameter int unsigned WIDTH = 96,
  parameter int unsigned DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush_i,
  input  logic                      push_i,
  input  logic [WIDTH-1:0]          data_i,
  input  logic                      pop_i,
  output logic [WIDTH-1:0]          data_o,
  output logic [$clog2(DEPTH):0]    count_o,
  output logic                      full_o,
  output logic                      empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE = AW'(1'b1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1'b1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             push_ok_s, pop_ok_s;

  assign empty_o   = (cnt_q == {CW{1'b0}});
  assign full_o    = (cnt_q == CNT_FULL);
  assign count_o   = cnt_q;
  assign data_o    = mem_q[rd_q];
  assign pop_ok_s  = pop_i && !empty_o;
  assign push_ok_s = push_i && (!full_o || pop_ok_s);

  // Pointer and occupancy next-state; flush discards everything.
  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      rd_d  = {AW{1'b0}};
      wr_d  = {AW{1'b0}};
      cnt_d = {CW{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_d = wr_q + PTR_ONE;
      end else begin
        wr_d = wr_q;
      end
      if (pop_ok_s) begin
        rd_d = rd_q + PTR_ONE;
      end else begin
        rd_d = rd_q;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   cnt_d = cnt_q + CNT_ONE;
        2'b01:   cnt_d = cnt_q - CNT_ONE;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q  <= {AW{1'b0}};
      wr_q  <= {AW{1'b0}};
      cnt_q <= {CW{1'b0}};
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage; contents are only meaningful while counted as occupied.
  always_ff @(posedge clk) begin
    if (push_ok_s && !flush_i) begin
      mem_q[wr_q] <= data_i;
    end
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: sequential PC generation, credit-limited icache
// requests, in-order response buffering and redirect handling with stale
// response discard.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        icache_req_valid_o,
  input  logic        icache_req_ready_i,
  output logic [63:0] icache_addr_o,
  input  logic        icache_resp_valid_i,
  input  logic [31:0] icache_inst_i,
  input  logic        redirect_valid_i,
  input  logic [63:0] redirect_pc_i,
  input  logic        id_stall_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [63:0] pc_o
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1'b1);
  localparam logic [CW:0]   DEPTH_L = (CW+1)'(DEPTH);

  logic [63:0]   fetch_pc_q, fetch_pc_d;
  logic [63:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] drop_q, drop_d;

  logic [CW-1:0] fifo_count_s;
  logic          fifo_full_s, fifo_empty_s;
  fetch_entry_t  head_s, push_entry_s;
  logic [CW:0]   credit_used_s;
  logic          req_valid_s, req_fire_s, resp_drop_s, push_s, pop_s;

  // Requests in flight plus buffered entries may never exceed the buffer
  // size, so every response is guaranteed a slot.
  assign credit_used_s = {1'b0, outst_q} + {1'b0, fifo_count_s};
  assign req_valid_s   = !rst && (credit_used_s < DEPTH_L);
  assign req_fire_s    = req_valid_s && icache_req_ready_i;
  assign resp_drop_s   = icache_resp_valid_i && (drop_q != {CW{1'b0}});
  assign push_s        = icache_resp_valid_i && !resp_drop_s && !redirect_valid_i
                         && (!fifo_full_s || pop_s);
  assign pop_s         = inst_valid_o && !id_stall_i && !redirect_valid_i;
  assign push_entry_s  = '{pc: resp_pc_q, inst: icache_inst_i};

  assign icache_req_valid_o = req_valid_s;
  assign icache_addr_o      = rst ? 64'h0000_0000_0000_0000 : fetch_pc_q;
  assign inst_valid_o       = !rst && !fifo_empty_s;
  assign inst_o             = inst_valid_o ? head_s.inst : NOP_INST;
  assign pc_o               = inst_valid_o ? head_s.pc : 64'h0000_0000_0000_0000;

  // Next-state for PCs and counters; a redirect overrides normal sequencing
  // and turns every request still owed a response into a stale one.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    outst_d    = outst_q;
    drop_d     = drop_q;

    if (req_fire_s && !icache_resp_valid_i) begin
      outst_d = outst_q + CNT_ONE;
    end else if (!req_fire_s && icache_resp_valid_i) begin
      outst_d = outst_q - CNT_ONE;
    end else begin
      outst_d = outst_q;
    end

    if (redirect_valid_i) begin
      fetch_pc_d = redirect_pc_i;
      resp_pc_d  = redirect_pc_i;
      drop_d     = outst_d;
    end else begin
      if (req_fire_s) begin
        fetch_pc_d = fetch_pc_q + PC_STEP;
      end else begin
        fetch_pc_d = fetch_pc_q;
      end
      if (push_s) begin
        resp_pc_d = resp_pc_q + PC_STEP;
      end else begin
        resp_pc_d = resp_pc_q;
      end
      if (resp_drop_s) begin
        drop_d = drop_q - CNT_ONE;
      end else begin
        drop_d = drop_q;
      end
    end
  end

  // PC and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= {CW{1'b0}};
      drop_q     <= {CW{1'b0}};
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

  if_fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (redirect_valid_i),
    .push_i  (push_s),
    .data_i  (push_entry_s),
    .pop_i   (pop_s),
    .data_o  (head_s),
    .count_o (fifo_count_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: a hand-derived vector table for reset, streaming,
// back-pressure, redirects and mid-flight reset, then randomized traffic
// against a queue-based reference model.
module tb_if_fetch;
  import if_fetch_pkg::*;

  localparam logic [63:0] B = 64'h0000_0000_8000_0000;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1, ready = 1'b0, resp_v = 1'b0, redir = 1'b0, stall = 1'b0;
  logic [31:0] inst_in = 32'h0;
  logic [63:0] rpc = 64'h0;
  logic        req_v, iv;
  logic [63:0] addr, pc;
  logic [31:0] inst;
  int          total = 0, bad = 0;

  if_fetch #(.RESET_PC(B), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .icache_req_valid_o(req_v), .icache_req_ready_i(ready), .icache_addr_o(addr),
    .icache_resp_valid_i(resp_v), .icache_inst_i(inst_in),
    .redirect_valid_i(redir), .redirect_pc_i(rpc), .id_stall_i(stall),
    .inst_valid_o(iv), .inst_o(inst), .pc_o(pc)
  );

  always #5 clk = ~clk;

  // Instruction word the fake icache returns for a given address.
  function automatic logic [31:0] ifn(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'hC3A5_1E0F;
  endfunction

  function automatic logic [63:0] ba(input int x);
    return B + 64'(x);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic r, rdy, rv; logic [63:0] raddr; logic rd; logic [63:0] rpc; logic st;
    logic e_rv; logic [63:0] e_addr; logic e_iv; logic [63:0] e_pc;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic r, rdy, rv, input logic [63:0] raddr, input logic rd,
                     input logic [63:0] rp, input logic st, input logic e_rv,
                     input logic [63:0] e_addr, input logic e_iv, input logic [63:0] e_pc);
    vec_t v;
    v = '{r, rdy, rv, raddr, rd, rp, st, e_rv, e_addr, e_iv, e_pc};
    tbl.push_back(v);
  endtask

  typedef struct { logic stale; logic [63:0] addr; } infl_t;
  typedef struct { logic [31:0] inst; logic [63:0] pc; } ent_t;
  infl_t       m_infl[$];
  ent_t        m_fifo[$];
  logic [63:0] m_fetch;
  logic [63:0] ic_q[$];
  infl_t       rs;
  ent_t        ne;
  logic        e_rv, e_iv, acc, have_rs;
  logic [63:0] e_pc;
  logic [31:0] e_inst;

  initial begin
    //   r rdy rv raddr     rd rpc       st  e_rv e_addr     e_iv e_pc
    add(1, 0, 0, 0,         0, 0,         0,  0, 0,          0, 0);
    add(1, 0, 0, 0,         0, 0,         0,  0, 0,          0, 0);
    add(0, 1, 0, 0,         0, 0,         0,  1, ba(0),      0, 0);
    add(0, 1, 1, ba(0),     0, 0,         0,  1, ba(4),      0, 0);
    add(0, 1, 1, ba(4),     0, 0,         0,  0, ba(8),      1, ba(0));
    add(0, 1, 0, 0,         0, 0,         0,  1, ba(8),      1, ba(4));
    add(0, 1, 1, ba(8),     0, 0,         0,  1, ba(12),     0, 0);
    add(0, 1, 1, ba(12),    0, 0,         1,  0, ba(16),     1, ba(8));
    add(0, 1, 0, 0,         0, 0,         1,  0, ba(16),     1, ba(8));
    add(0, 1, 0, 0,         0, 0,         0,  0, ba(16),     1, ba(8));
    add(0, 1, 0, 0,         0, 0,         0,  1, ba(16),     1, ba(12));
    add(0, 1, 0, 0,         0, 0,         0,  1, ba(20),     0, 0);
    add(0, 1, 0, 0,         1, ba(256),   0,  0, ba(24),     0, 0);
    add(0, 1, 1, ba(16),    0, 0,         0,  0, ba(256),    0, 0);
    add(0, 1, 1, ba(20),    0, 0,         0,  1, ba(256),    0, 0);
    add(0, 1, 1, ba(256),   0, 0,         0,  1, ba(260),    0, 0);
    add(0, 0, 0, 0,         0, 0,         1,  0, ba(264),    1, ba(256));
    add(0, 1, 1, ba(260),   1, ba(258),   0,  0, ba(264),    1, ba(256));
    add(0, 1, 0, 0,         0, 0,         0,  1, ba(258),    0, 0);
    add(0, 0, 1, ba(258),   0, 0,         0,  1, ba(262),    0, 0);
    add(0, 0, 0, 0,         0, 0,         0,  1, ba(262),    1, ba(258));
    add(0, 1, 0, 0,         0, 0,         0,  1, ba(262),    0, 0);
    add(0, 1, 1, ba(262),   0, 0,         1,  1, ba(266),    0, 0);
    add(1, 1, 0, 0,         0, 0,         1,  0, 0,          0, 0);
    add(0, 0, 0, 0,         0, 0,         0,  1, ba(0),      0, 0);
    add(0, 1, 0, 0,         0, 0,         0,  1, ba(0),      0, 0);
    add(0, 1, 0, 0,         0, 0,         0,  1, ba(4),      0, 0);
    add(0, 0, 0, 0,         0, 0,         0,  0, ba(8),      0, 0);

    foreach (tbl[i]) begin
      @(negedge clk);
      rst = tbl[i].r; ready = tbl[i].rdy; resp_v = tbl[i].rv;
      inst_in = ifn(tbl[i].raddr); redir = tbl[i].rd; rpc = tbl[i].rpc; stall = tbl[i].st;
      #1;
      chk($sformatf("vec%0d.req_valid", i), {63'h0, req_v}, {63'h0, tbl[i].e_rv});
      chk($sformatf("vec%0d.addr", i), addr, tbl[i].e_addr);
      chk($sformatf("vec%0d.inst_valid", i), {63'h0, iv}, {63'h0, tbl[i].e_iv});
      chk($sformatf("vec%0d.pc", i), pc, tbl[i].e_pc);
      chk($sformatf("vec%0d.inst", i), {32'h0, inst},
          {32'h0, tbl[i].e_iv ? ifn(tbl[i].e_pc) : NOP_INST});
    end

    // Randomized traffic against the reference model.
    m_fetch = B;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      rst    = (c < 2) || ($urandom_range(0, 299) == 0);
      ready  = ($urandom_range(0, 3) != 0);
      resp_v = !rst && (ic_q.size() > 0) && ($urandom_range(0, 2) != 0);
      inst_in = resp_v ? ifn(ic_q[0]) : $urandom();
      redir  = !rst && ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 3))
        0:       rpc = {$urandom(), $urandom()} & ~64'h3;
        1:       rpc = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 3)) * 64'd4;
        2:       rpc = B + 64'($urandom_range(0, 255));
        default: rpc = B + 64'($urandom_range(0, 63)) * 64'd4;
      endcase
      stall = ($urandom_range(0, 2) == 0);
      #1;

      e_rv = !rst && ((m_infl.size() + m_fifo.size()) < DEPTH);
      e_iv = !rst && (m_fifo.size() > 0);
      e_pc = e_iv ? m_fifo[0].pc : 64'h0;
      e_inst = e_iv ? m_fifo[0].inst : NOP_INST;
      chk("rnd.req_valid", {63'h0, req_v}, {63'h0, e_rv});
      chk("rnd.addr", addr, rst ? 64'h0 : m_fetch);
      chk("rnd.inst_valid", {63'h0, iv}, {63'h0, e_iv});
      chk("rnd.pc", pc, e_pc);
      chk("rnd.inst", {32'h0, inst}, {32'h0, e_inst});

      if (rst) begin
        ic_q.delete(); m_infl.delete(); m_fifo.delete(); m_fetch = B;
      end else begin
        if (req_v && ready) ic_q.push_back(addr);
        if (resp_v) void'(ic_q.pop_front());
        acc = e_rv && ready;
        have_rs = 1'b0;
        if (resp_v) begin
          if (m_infl.size() > 0) begin
            rs = m_infl.pop_front();
            have_rs = 1'b1;
          end else begin
            total++; bad++;
            $display("FAIL rnd.spurious_resp: got response with %0d in flight, want none", 0);
          end
        end
        if (redir) begin
          if (acc) m_infl.push_back('{1'b1, m_fetch});
          foreach (m_infl[k]) m_infl[k].stale = 1'b1;
          m_fifo.delete();
          m_fetch = rpc;
        end else begin
          if (m_fifo.size() > 0 && !stall) void'(m_fifo.pop_front());
          if (have_rs && !rs.stale) begin
            ne = '{inst_in, rs.addr};
            m_fifo.push_back(ne);
          end
          if (acc) begin
            m_infl.push_back('{1'b0, m_fetch});
            m_fetch = m_fetch + 64'd4;
          end
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
